// File: rtl/psc_axil_pkg.sv
// Shared types and constants for the PSC FSM controller AXI4-Lite register block.
package psc_axil_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         ADDR_LSB  = 2;
    localparam int         NUM_REGS  = 4;
    localparam int         IDX_W     = 2;

    typedef enum logic [2:0] {
        W_INIT,
        W_IDLE,
        W_WAIT_DATA,
        W_WAIT_ADDR,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_INIT,
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Byte-lane merge: lanes with a clear strobe keep their previous contents.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/psc_fsm_ctrl_axil_slave.sv
// AXI4-Lite responder exposing four 32-bit RW configuration registers to the
// 3-phase FSM controller, with a one-cycle write pulse per register.
//
// Write FSM
//   state       | meaning
//   W_INIT      | first cycle after reset, all readies low
//   W_IDLE      | accepting AW and W together or separately
//   W_WAIT_DATA | address latched, waiting for write data
//   W_WAIT_ADDR | data latched, waiting for write address
//   W_RESP      | write committed, holding BVALID until BREADY
// Read FSM
//   state       | meaning
//   R_INIT      | first cycle after reset, ARREADY low
//   R_IDLE      | accepting a read address
//   R_DATA      | holding RVALID/RDATA until RREADY
module psc_fsm_ctrl_axil_slave
    import psc_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic [31:0]      slv_regs [NUM_REGS];
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      rdata_q;
    logic [NUM_REGS-1:0] wr_pulse_q;

    logic             wr_commit;
    logic             wr_latch_addr;
    logic             wr_latch_data;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic             rd_capture;

    logic [IDX_W-1:0] aw_idx_in;
    logic [IDX_W-1:0] ar_idx_in;

    // Byte-offset bits and protection attributes carry no meaning for this block.
    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign aw_idx_in = S_AXI_AWADDR[ADDR_LSB +: IDX_W];
    assign ar_idx_in = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

    // State registers for both channel FSMs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wr_state <= W_INIT;
            rd_state <= R_INIT;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    // Write next-state and commit/latch decisions.
    always_comb begin
        wr_state_nxt  = wr_state;
        wr_commit     = 1'b0;
        wr_latch_addr = 1'b0;
        wr_latch_data = 1'b0;
        wr_idx        = aw_idx_q;
        wr_data       = wdata_q;
        wr_strb       = wstrb_q;
        case (wr_state)
            W_INIT: begin
                wr_state_nxt = W_IDLE;
            end
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wr_commit    = 1'b1;
                    wr_idx       = aw_idx_in;
                    wr_data      = S_AXI_WDATA;
                    wr_strb      = S_AXI_WSTRB;
                    wr_state_nxt = W_RESP;
                end else if (S_AXI_AWVALID) begin
                    wr_latch_addr = 1'b1;
                    wr_state_nxt  = W_WAIT_DATA;
                end else if (S_AXI_WVALID) begin
                    wr_latch_data = 1'b1;
                    wr_state_nxt  = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                if (S_AXI_WVALID) begin
                    wr_commit    = 1'b1;
                    wr_data      = S_AXI_WDATA;
                    wr_strb      = S_AXI_WSTRB;
                    wr_state_nxt = W_RESP;
                end
            end
            W_WAIT_ADDR: begin
                if (S_AXI_AWVALID) begin
                    wr_commit    = 1'b1;
                    wr_idx       = aw_idx_in;
                    wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_nxt = W_IDLE;
                end
            end
            default: begin
                wr_state_nxt = W_INIT;
            end
        endcase
    end

    // Read next-state and address capture decision.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_capture   = 1'b0;
        case (rd_state)
            R_INIT: begin
                rd_state_nxt = R_IDLE;
            end
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rd_capture   = 1'b1;
                    rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_nxt = R_IDLE;
                end
            end
            default: begin
                rd_state_nxt = R_INIT;
            end
        endcase
    end

    // Register file, half-transaction latches, write pulses and read data.
    // A read captured on the same edge as a write commit sees the old value.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                slv_regs[i] <= '0;
            end
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_commit) begin
                slv_regs[wr_idx]   <= apply_wstrb(slv_regs[wr_idx], wr_data, wr_strb);
                wr_pulse_q[wr_idx] <= 1'b1;
            end
            if (wr_latch_addr) begin
                aw_idx_q <= aw_idx_in;
            end
            if (wr_latch_data) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (rd_capture) begin
                rdata_q <= slv_regs[ar_idx_in];
            end
        end
    end

    assign S_AXI_AWREADY = (wr_state == W_IDLE) || (wr_state == W_WAIT_ADDR);
    assign S_AXI_WREADY  = (wr_state == W_IDLE) || (wr_state == W_WAIT_DATA);
    assign S_AXI_BVALID  = (wr_state == W_RESP);
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = (rd_state == R_IDLE);
    assign S_AXI_RVALID  = (rd_state == R_DATA);
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RDATA   = rdata_q;

    assign slv_reg0     = slv_regs[0];
    assign slv_reg1     = slv_regs[1];
    assign slv_reg2     = slv_regs[2];
    assign slv_reg3     = slv_regs[3];
    assign reg_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_psc_fsm_ctrl_axil_slave.sv
// Directed self-checking bench for the PSC FSM controller AXI4-Lite register block.
module tb_psc_fsm_ctrl_axil_slave;

    logic        tb_ACLK = 1'b0;
    logic        S_AXI_ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
    logic [3:0]  reg_wr_pulse;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt    = 0;
    int exp_pulses   = 0;

    psc_fsm_ctrl_axil_slave dut (
        .S_AXI_ACLK    (tb_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .slv_reg0      (slv_reg0),
        .slv_reg1      (slv_reg1),
        .slv_reg2      (slv_reg2),
        .slv_reg3      (slv_reg3),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    // Every cycle a pulse bit is high counts once; a stretched pulse shows up here.
    always @(negedge tb_ACLK) pulse_cnt += $countones(reg_wr_pulse);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] pulse);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_done  = 1; S_AXI_WVALID  = 1'b0; end
            n++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("wr_handshake_bound", 32'(n < 20), 32'd1);
        exp_pulses++;
        check("wr_bvalid_latency", 32'(S_AXI_BVALID), 32'd1);
        resp  = S_AXI_BRESP;
        pulse = reg_wr_pulse;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("wr_bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_hs = 0;
        int n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!ar_hs && n < 20) begin
            ar_hs = S_AXI_ARREADY;
            tick();
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        check("rd_handshake_bound", 32'(ar_hs), 32'd1);
        check("rd_rvalid_latency", 32'(S_AXI_RVALID), 32'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        check("rd_rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
    endtask

    logic [3:0]  wr_addrs [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
    logic [31:0] wr_datas [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [31:0] rd;
        logic [31:0] regs_now [4];

        S_AXI_ARESETN = 1'b0;
        S_AXI_AWADDR  = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;

        // Reset and INIT cycle
        tick(); tick(); tick();
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst_rdata",   S_AXI_RDATA, 32'd0);
        check("rst_regs",    slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3, 32'd0);
        check("rst_pulse",   32'(reg_wr_pulse), 32'd0);
        S_AXI_ARESETN = 1'b1;
        check("init_awready", 32'(S_AXI_AWREADY), 32'd0);
        tick();
        check("idle_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("idle_wready",  32'(S_AXI_WREADY),  32'd1);
        check("idle_arready", 32'(S_AXI_ARREADY), 32'd1);

        // Basic write then read-back of all four registers
        for (int i = 0; i < 4; i++) begin
            axi_write(wr_addrs[i], wr_datas[i], 4'hF, resp, pulse);
            check("wr_bresp", 32'(resp), 32'd0);
            check("wr_pulse", 32'(pulse), 32'(4'b0001 << i));
        end
        regs_now = '{slv_reg0, slv_reg1, slv_reg2, slv_reg3};
        for (int i = 0; i < 4; i++) begin
            check("slv_reg", regs_now[i], wr_datas[i]);
            axi_read(wr_addrs[i], rd, resp);
            check("rd_data", rd, wr_datas[i]);
            check("rd_rresp", 32'(resp), 32'd0);
        end

        // Address ahead of data
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wd_awready", 32'(S_AXI_AWREADY), 32'd0);
            check("wd_wready",  32'(S_AXI_WREADY),  32'd1);
            check("wd_bvalid",  32'(S_AXI_BVALID),  32'd0);
            tick();
        end
        check("wd_reg1_hold", slv_reg1, 32'hABCD0001);
        S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        exp_pulses++;
        check("wd_bvalid_rise", 32'(S_AXI_BVALID), 32'd1);
        check("wd_reg1",        slv_reg1, 32'h11223344);
        check("wd_pulse",       32'(reg_wr_pulse), 32'h2);
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;

        // Data ahead of address
        S_AXI_WDATA = 32'hA5A55A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wa_awready", 32'(S_AXI_AWREADY), 32'd1);
            check("wa_wready",  32'(S_AXI_WREADY),  32'd0);
            check("wa_bvalid",  32'(S_AXI_BVALID),  32'd0);
            tick();
        end
        check("wa_reg1_hold", slv_reg1, 32'h11223344);
        S_AXI_WDATA = 32'h0; S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        exp_pulses++;
        check("wa_bvalid_rise", 32'(S_AXI_BVALID), 32'd1);
        check("wa_reg1",        slv_reg1, 32'hA5A55A5A);
        check("wa_pulse",       32'(reg_wr_pulse), 32'h2);
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;

        // Byte strobe merge on an unaligned address
        axi_write(4'h4, 32'hABCD0001, 4'hF, resp, pulse);
        axi_write(4'h5, 32'h12345678, 4'b0010, resp, pulse);
        check("strb_reg1",  slv_reg1, 32'hABCD5601);
        check("strb_pulse", 32'(pulse), 32'h2);
        axi_write(4'h4, 32'hFFFFFFFF, 4'b0000, resp, pulse);
        check("strb0_reg1",  slv_reg1, 32'hABCD5601);
        check("strb0_pulse", 32'(pulse), 32'h2);
        check("strb0_bresp", 32'(resp), 32'd0);

        // B backpressure blocks a second write
        S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h0F0F0F0F; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        exp_pulses++;
        S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h77777777;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid",  32'(S_AXI_BVALID),  32'd1);
            check("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
            check("bp_wready",  32'(S_AXI_WREADY),  32'd0);
            tick();
        end
        check("bp_reg0", slv_reg0, 32'h0F0F0F0F);
        check("bp_reg3_hold", slv_reg3, 32'hBEEF0011);
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        check("bp_bvalid_clear", 32'(S_AXI_BVALID),  32'd0);
        check("bp_awready_back", 32'(S_AXI_AWREADY), 32'd1);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        exp_pulses++;
        check("bp2_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("bp2_reg3",   slv_reg3, 32'h77777777);
        check("bp2_pulse",  32'(reg_wr_pulse), 32'h8);
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;

        // R backpressure
        S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rp_rvalid",  32'(S_AXI_RVALID),  32'd1);
            check("rp_rdata",   S_AXI_RDATA, 32'h0F0F0F0F);
            check("rp_arready", 32'(S_AXI_ARREADY), 32'd0);
            tick();
        end
        S_AXI_RREADY = 1'b1; tick(); S_AXI_RREADY = 1'b0;
        check("rp_rvalid_clear", 32'(S_AXI_RVALID),  32'd0);
        check("rp_rdata_retain", S_AXI_RDATA, 32'h0F0F0F0F);
        check("rp_arready_back", 32'(S_AXI_ARREADY), 32'd1);

        // Read racing a write commit to the same register
        S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        exp_pulses++;
        check("race_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("race_rdata",  S_AXI_RDATA, 32'hDEAD0011);
        check("race_reg2",   slv_reg2, 32'hCAFEF00D);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(4'h8, rd, resp);
        check("race_reread", rd, 32'hCAFEF00D);

        // Reset while a write response is pending
        S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h12121212; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        exp_pulses++;
        check("mr_bvalid_pre", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_ARESETN = 1'b0;
        tick();
        S_AXI_ARESETN = 1'b1;
        check("mr_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("mr_regs",    slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3, 32'd0);
        check("mr_rdata",   S_AXI_RDATA, 32'd0);
        check("mr_pulse",   32'(reg_wr_pulse), 32'd0);
        check("mr_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("mr_wready",  32'(S_AXI_WREADY),  32'd0);
        check("mr_arready", 32'(S_AXI_ARREADY), 32'd0);
        tick();
        check("mr_awready_up", 32'(S_AXI_AWREADY), 32'd1);
        check("mr_wready_up",  32'(S_AXI_WREADY),  32'd1);
        check("mr_arready_up", 32'(S_AXI_ARREADY), 32'd1);
        check("mr_bvalid_stay", 32'(S_AXI_BVALID), 32'd0);
        tick();

        check("pulse_total", 32'(pulse_cnt), 32'(exp_pulses));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
